// File: rtl/jtframe_ioctl_prog.sv
// SPI download byte stream to masked 16-bit SDRAM programming writes.
// A small FIFO absorbs bytes while the SDRAM controller has a write in flight.
module jtframe_ioctl_prog #(
  parameter int          SDRAMW    = 23,
  parameter int          HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h200000,
  parameter logic [24:0] BA3_START = 25'h300000,
  parameter int          FIFO_AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  // state | meaning
  // IDLE  | no write outstanding, pops the FIFO when it holds a byte
  // WAIT  | prog_we high, prog_* frozen until prog_rdy
  // GAP   | one low cycle of prog_we so the controller sees an edge
  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  localparam int          DEPTH = 1 << FIFO_AW;
  localparam logic [24:0] HDR   = 25'(HEADER);

  state_t state, state_nxt;

  logic [24:0]        fifo_addr [DEPTH];
  logic [7:0]         fifo_data [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, push, pop, accept;

  logic [24:0]        rel, base, off;
  logic [1:0]         bank;

  logic [SDRAMW-1:0]  addr_nxt;
  logic [15:0]        data_nxt;
  logic [1:0]         mask_nxt, ba_nxt;
  logic               we_nxt;

  assign empty  = (count == '0);
  assign full   = (count == (FIFO_AW+1)'(DEPTH));
  assign push   = ioctl_wr & downloading & (ioctl_addr >= HDR);
  // a full FIFO still accepts when the head leaves in the same cycle
  assign accept = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_addr[wr_ptr] <= ioctl_addr;
      fifo_data[wr_ptr] <= ioctl_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    rel  = fifo_addr[rd_ptr] - HDR;
    bank = 2'd0;
    base = '0;
    if (rel >= BA3_START) begin
      bank = 2'd3;
      base = BA3_START;
    end else if (rel >= BA2_START) begin
      bank = 2'd2;
      base = BA2_START;
    end else if (rel >= BA1_START) begin
      bank = 2'd1;
      base = BA1_START;
    end
    off = rel - base;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    we_nxt    = prog_we;
    addr_nxt  = prog_addr;
    data_nxt  = prog_data;
    mask_nxt  = prog_mask;
    ba_nxt    = prog_ba;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = SDRAMW'(off >> 1);
          data_nxt  = {fifo_data[rd_ptr], fifo_data[rd_ptr]};
          mask_nxt  = off[0] ? 2'b01 : 2'b10;
          ba_nxt    = bank;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (prog_rdy) begin
          we_nxt    = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        we_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_ba   <= 2'd0;
    end else begin
      state     <= state_nxt;
      prog_we   <= we_nxt;
      prog_addr <= addr_nxt;
      prog_data <= data_nxt;
      prog_mask <= mask_nxt;
      prog_ba   <= ba_nxt;
    end
  end

  assign dwnld_busy = downloading | ~empty | (state != IDLE);

endmodule

// File: tb/tb_jtframe_ioctl_prog.sv
// Bench for jtframe_ioctl_prog: table vectors, corner sequences and a random
// byte stream checked against an arithmetic bank/offset reference.
`timescale 1ns/1ps
module tb_jtframe_ioctl_prog;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, downloading, ioctl_wr, prog_rdy, sel;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [22:0] a0, a4;
  logic [15:0] d0, d4;
  logic [1:0]  m0, m4, b0, b4;
  logic        we0, we4, busy0, busy4, ov0, ov4;

  jtframe_ioctl_prog dut0 (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr & ~sel),
    .prog_addr(a0), .prog_data(d0), .prog_mask(m0), .prog_ba(b0), .prog_we(we0),
    .prog_rdy(prog_rdy & ~sel), .dwnld_busy(busy0), .overflow(ov0));

  jtframe_ioctl_prog #(.HEADER(4)) dut4 (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr & sel),
    .prog_addr(a4), .prog_data(d4), .prog_mask(m4), .prog_ba(b4), .prog_we(we4),
    .prog_rdy(prog_rdy & sel), .dwnld_busy(busy4), .overflow(ov4));

  wire [22:0] a_o    = sel ? a4 : a0;
  wire [15:0] dat_o  = sel ? d4 : d0;
  wire [1:0]  m_o    = sel ? m4 : m0;
  wire [1:0]  b_o    = sel ? b4 : b0;
  wire        we_o   = sel ? we4 : we0;
  wire        busy_o = sel ? busy4 : busy0;
  wire        ov_o   = sel ? ov4 : ov0;

  typedef struct packed {
    logic [1:0]  ba;
    logic [22:0] wa;
    logic [1:0]  mask;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  d;
    wr_t         exp;
  } vec_t;

  wr_t  exp_q[$];
  vec_t tbl[10];
  int   checks = 0, errors = 0;
  int   rdy_delay = 3, done_cnt = 0;
  bit   rdy_hold = 1'b1, in_service = 1'b0, rnd_delay = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic wr_t ref_map(logic [24:0] addr, logic [7:0] d, int hdr);
    longint a, start, o;
    wr_t w;
    a = longint'(addr) - hdr;
    if (a >= 'h300000)      begin w.ba = 2'd3; start = 'h300000; end
    else if (a >= 'h200000) begin w.ba = 2'd2; start = 'h200000; end
    else if (a >= 'h100000) begin w.ba = 2'd1; start = 'h100000; end
    else                    begin w.ba = 2'd0; start = 0;        end
    o      = a - start;
    w.wa   = 23'((o / 2) % (longint'(1) << 23));
    w.mask = (o % 2 == 1) ? 2'b01 : 2'b10;
    w.data = {d, d};
    return w;
  endfunction

  function automatic vec_t mk(logic [24:0] addr, logic [7:0] d, logic [1:0] ba,
                              logic [22:0] wa, logic [1:0] mask);
    vec_t v;
    v.addr = addr;
    v.d    = d;
    v.exp  = '{ba: ba, wa: wa, mask: mask, data: {d, d}};
    return v;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(logic [24:0] a, logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_service) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d writes pending, expected 0", name, exp_q.size());
    end
    tick(3);
  endtask

  // SDRAM controller stand-in: acknowledges each write and scores it
  initial begin
    wr_t got, e;
    int  dly;
    prog_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (we_o && !rdy_hold && !rst) begin
        in_service = 1'b1;
        got = wr_t'({b_o, a_o, m_o, dat_o});
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %h expected none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write: got %h expected %h", got, e);
          end
        end
        dly = rnd_delay ? int'($urandom_range(0, 4)) : rdy_delay;
        repeat (dly) begin @(posedge clk); #1; end
        chk("held_stable", {b_o, a_o, m_o, dat_o, we_o}, {got, 1'b1});
        prog_rdy = 1'b1;
        @(posedge clk); #1;
        prog_rdy = 1'b0;
        done_cnt++;
        in_service = 1'b0;
        chk("we_fell", we_o, 0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done0;
    logic [24:0] ra;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; sel = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;

    tbl[0] = mk(25'h0000000, 8'h11, 2'd0, 23'h000000, 2'b10);
    tbl[1] = mk(25'h0000001, 8'h22, 2'd0, 23'h000000, 2'b01);
    tbl[2] = mk(25'h0100004, 8'hAB, 2'd1, 23'h000002, 2'b10);
    tbl[3] = mk(25'h00FFFFF, 8'h5C, 2'd0, 23'h07FFFF, 2'b01);
    tbl[4] = mk(25'h0100000, 8'h01, 2'd1, 23'h000000, 2'b10);
    tbl[5] = mk(25'h0200003, 8'h7E, 2'd2, 23'h000001, 2'b01);
    tbl[6] = mk(25'h01FFFFF, 8'h3C, 2'd1, 23'h07FFFF, 2'b01);
    tbl[7] = mk(25'h0300000, 8'hC3, 2'd3, 23'h000000, 2'b10);
    tbl[8] = mk(25'h1FFFFFF, 8'h99, 2'd3, 23'h67FFFF, 2'b01);
    tbl[9] = mk(25'h02FFFFE, 8'h44, 2'd2, 23'h07FFFF, 2'b10);

    tick(3);
    chk("rst_we",   we_o,   0);
    chk("rst_addr", a_o,    0);
    chk("rst_data", dat_o,  0);
    chk("rst_mask", m_o,    2'b11);
    chk("rst_ba",   b_o,    0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf",  ov_o,   0);
    rst = 1'b0;
    tick();

    // table vectors, first one with the two-cycle issue latency checked
    downloading = 1'b1;
    rdy_hold    = 1'b0;
    rdy_delay   = 3;
    exp_q.push_back(tbl[0].exp);
    ioctl_addr = tbl[0].addr; ioctl_dout = tbl[0].d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    chk("latency_1clk", we_o, 0);
    tick();
    chk("latency_2clk", we_o, 1);
    tick(7);
    for (int i = 1; i < 10; i++) begin
      exp_q.push_back(tbl[i].exp);
      send(tbl[i].addr, tbl[i].d);
      tick(7);
    end
    wait_idle("table_drain", 200);
    chk("busy_while_downloading", busy_o, 1);

    // bytes outside the download window are ignored
    downloading = 1'b0;
    send(25'h40, 8'hEE);
    for (int i = 0; i < 6; i++) begin
      chk("ignored_no_we", we_o, 0);
      tick();
    end
    chk("ignored_busy", busy_o, 0);

    // HEADER=4 instance: bytes 0..3 discarded
    sel = 1'b1;
    downloading = 1'b1;
    exp_q.push_back('{ba: 2'd0, wa: 23'd0, mask: 2'b10, data: 16'h3434});
    exp_q.push_back('{ba: 2'd0, wa: 23'd0, mask: 2'b01, data: 16'h3535});
    for (int i = 0; i < 6; i++) begin
      send(25'(i), 8'(8'h30 + i));
      tick(7);
    end
    wait_idle("header_drain", 200);
    chk("header_ovf", ov_o, 0);
    sel = 1'b0;

    // FIFO fill with controller stalled, then one byte too many
    rdy_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ref_map(25'(25'h10 + i), 8'(8'hA0 + i), 0));
      ioctl_addr = 25'(25'h10 + i); ioctl_dout = 8'(8'hA0 + i); ioctl_wr = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    chk("fill_no_ovf", ov_o, 0);
    chk("fill_issued", we_o, 1);
    send(25'h15, 8'hA5);
    chk("fill_ovf", ov_o, 1);
    rdy_delay = 1;
    rdy_hold  = 1'b0;
    wait_idle("fill_drain", 300);
    chk("ovf_sticky", ov_o, 1);

    // download ends with writes still queued
    rdy_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ref_map(25'(25'h200 + i), 8'(8'h60 + i), 0));
      ioctl_addr = 25'(25'h200 + i); ioctl_dout = 8'(8'h60 + i); ioctl_wr = 1'b1;
      tick();
    end
    ioctl_wr    = 1'b0;
    downloading = 1'b0;
    tick();
    chk("tail_busy_stalled", busy_o, 1);
    done0     = done_cnt;
    rdy_delay = 2;
    rdy_hold  = 1'b0;
    n = 0;
    while (done_cnt < done0 + 4 && n < 200) begin
      @(posedge clk); #2;
      if (!busy_o) begin
        n = 1000;
      end
      n++;
    end
    chk("tail_busy_until_last", n < 200, 1);
    chk("tail_busy_gap", busy_o, 1);
    @(posedge clk); #2;
    chk("tail_busy_drop", busy_o, 0);
    tick();

    // reset while a write is waiting and another is queued
    downloading = 1'b1;
    rdy_hold    = 1'b1;
    exp_q.push_back(ref_map(25'h500, 8'h5A, 0));
    send(25'h500, 8'h5A);
    send(25'h501, 8'h5B);
    tick(2);
    chk("pre_rst_we", we_o, 1);
    downloading = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_we",   we_o,   0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_mask", m_o,    2'b11);
    chk("mid_rst_addr", a_o,    0);
    chk("mid_rst_ovf",  ov_o,   0);
    rst = 1'b0;
    exp_q.delete();
    rdy_hold = 1'b0;
    tick(10);
    chk("post_rst_we",   we_o,   0);
    chk("post_rst_busy", busy_o, 0);

    // random stream against the reference map
    downloading = 1'b1;
    rnd_delay   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      n = 0;
      while (exp_q.size() + int'(in_service) > 3 && n < 100) begin
        tick();
        n++;
      end
      if (($urandom & 3) == 0) ra = 25'($urandom);
      else ra = 25'(($urandom_range(0, 3) << 20) + $urandom_range(0, 25'hFFFFF));
      ioctl_dout = 8'($urandom);
      exp_q.push_back(ref_map(ra, ioctl_dout, 0));
      send(ra, ioctl_dout);
      tick($urandom_range(0, 3));
    end
    wait_idle("random_drain", 2000);
    chk("random_ovf", ov_o, 0);
    downloading = 1'b0;
    tick(3);
    chk("final_busy", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
